// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode values understood by
// the shared ALU and the number of requesting ports.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_OR      = 4'd2;
    localparam logic [3:0] OP_LUI     = 4'd3;
    localparam logic [3:0] OP_SLL     = 4'd4;
    localparam logic [3:0] OP_SIGNCOM = 4'd5;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the port that wins a tie and
// flips to the losing side after every grant; FIXED_PRI0 pins ties to port 0.
module rr_arb2 #(
    parameter bit FIXED_PRI0 = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = (FIXED_PRI0 || !ptr_q) ? 2'b01 : 2'b10;
        end
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = 1'b1;
        end else if (grant[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: a single issue register
// feeds the ALU and each port owns a one-entry response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W          = 32,
    parameter int TAG_W      = 4,
    parameter bit FIXED_PRI0 = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_b1,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [4:0]       req_shamt0,
    input  logic [4:0]       req_shamt1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_op,
    output logic [4:0]       alu_shamt,
    input  logic [W-1:0]     alu_c,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_data0,
    output logic [W-1:0]     rsp_data1,
    output logic [TAG_W-1:0] rsp_tag0,
    output logic [TAG_W-1:0] rsp_tag1
);

    typedef struct packed {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
        logic             valid;
    } slot_t;

    logic             iss_valid_q, iss_valid_d;
    logic             iss_port_q, iss_port_d;
    logic [W-1:0]     iss_a_q, iss_a_d;
    logic [W-1:0]     iss_b_q, iss_b_d;
    logic [3:0]       iss_op_q, iss_op_d;
    logic [4:0]       iss_shamt_q, iss_shamt_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    slot_t            slot_q [NUM_PORTS];
    slot_t            slot_d [NUM_PORTS];

    logic [1:0] drain;
    logic [1:0] land;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       iss_free;

    // The issued op lands only when its slot is free; otherwise it waits in the
    // issue register, and no new op can be accepted behind it.
    always_comb begin
        drain = 2'b00;
        land  = 2'b00;
        elig  = 2'b00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drain[p] = slot_q[p].valid & rsp_ready[p];
        end
        if (iss_valid_q) begin
            land[iss_port_q] = ~slot_q[iss_port_q].valid | drain[iss_port_q];
        end
        iss_free = ~iss_valid_q | (|land);
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = req_valid[p] & (~slot_q[p].valid | rsp_ready[p]) & iss_free;
        end
    end

    rr_arb2 #(
        .FIXED_PRI0 (FIXED_PRI0)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .elig  (elig),
        .grant (grant)
    );

    always_comb begin
        iss_valid_d = iss_valid_q & ~(|land);
        iss_port_d  = iss_port_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_op_d    = iss_op_q;
        iss_shamt_d = iss_shamt_q;
        iss_tag_d   = iss_tag_q;
        if (grant[0]) begin
            iss_valid_d = 1'b1;
            iss_port_d  = 1'b0;
            iss_a_d     = req_a0;
            iss_b_d     = req_b0;
            iss_op_d    = req_op0;
            iss_shamt_d = req_shamt0;
            iss_tag_d   = req_tag0;
        end else if (grant[1]) begin
            iss_valid_d = 1'b1;
            iss_port_d  = 1'b1;
            iss_a_d     = req_a1;
            iss_b_d     = req_b1;
            iss_op_d    = req_op1;
            iss_shamt_d = req_shamt1;
            iss_tag_d   = req_tag1;
        end
        // A landing result overrides a drain, giving back-to-back responses.
        for (int p = 0; p < NUM_PORTS; p++) begin
            slot_d[p] = slot_q[p];
            if (drain[p]) begin
                slot_d[p].valid = 1'b0;
            end
            if (land[p]) begin
                slot_d[p] = '{data: alu_c, tag: iss_tag_q, valid: 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_valid_q <= 1'b0;
            iss_port_q  <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_op_q    <= '0;
            iss_shamt_q <= '0;
            iss_tag_q   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                slot_q[p] <= '0;
            end
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_port_q  <= iss_port_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_op_q    <= iss_op_d;
            iss_shamt_q <= iss_shamt_d;
            iss_tag_q   <= iss_tag_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                slot_q[p] <= slot_d[p];
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = {slot_q[1].valid, slot_q[0].valid};
    assign rsp_data0 = slot_q[0].data;
    assign rsp_data1 = slot_q[1].data;
    assign rsp_tag0  = slot_q[0].tag;
    assign rsp_tag1  = slot_q[1].tag;
    assign alu_a     = iss_valid_q ? iss_a_q     : '0;
    assign alu_b     = iss_valid_q ? iss_b_q     : '0;
    assign alu_op    = iss_valid_q ? iss_op_q    : '0;
    assign alu_shamt = iss_valid_q ? iss_shamt_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, with per-port
// expected-response queues checked by an independent monitor.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_op0, req_op1, req_tag0, req_tag1;
    logic [4:0]  req_shamt0, req_shamt1;
    logic [31:0] alu_a, alu_b, alu_c, rsp_data0, rsp_data1;
    logic [3:0]  alu_op, rsp_tag0, rsp_tag1;
    logic [4:0]  alu_shamt;

    logic [1:0]  f_req_ready, f_rsp_valid, f_rsp_ready;
    logic [31:0] f_alu_a, f_alu_b, f_alu_c, f_rsp_data0, f_rsp_data1;
    logic [3:0]  f_alu_op, f_rsp_tag0, f_rsp_tag1;
    logic [4:0]  f_alu_shamt;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q0[$];
    logic [35:0] exp_q1[$];

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op, input logic [4:0] sh);
        case (op)
            OP_ADD:     return a + b;
            OP_SUB:     return a - b;
            OP_OR:      return a | b;
            OP_LUI:     return b << 16;
            OP_SLL:     return b << sh;
            OP_SIGNCOM: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    assign alu_c       = alu_model(alu_a, alu_b, alu_op, alu_shamt);
    assign f_alu_c     = alu_model(f_alu_a, f_alu_b, f_alu_op, f_alu_shamt);
    assign f_rsp_ready = 2'b11;

    alu_arbiter #(.W(32), .TAG_W(4), .FIXED_PRI0(1'b0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
        .req_tag0(req_tag0), .req_tag1(req_tag1), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_c(alu_c), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1)
    );

    alu_arbiter #(.W(32), .TAG_W(4), .FIXED_PRI0(1'b1)) dut_fix (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
        .req_tag0(req_tag0), .req_tag1(req_tag1), .alu_a(f_alu_a), .alu_b(f_alu_b),
        .alu_op(f_alu_op), .alu_shamt(f_alu_shamt), .alu_c(f_alu_c), .rsp_valid(f_rsp_valid),
        .rsp_ready(f_rsp_ready), .rsp_data0(f_rsp_data0), .rsp_data1(f_rsp_data1),
        .rsp_tag0(f_rsp_tag0), .rsp_tag1(f_rsp_tag1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int p, input logic v, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] op,
                                  input logic [4:0] sh, input logic [3:0] tag);
        if (p == 0) begin
            req_valid[0] = v; req_a0 = a; req_b0 = b; req_op0 = op; req_shamt0 = sh; req_tag0 = tag;
        end else begin
            req_valid[1] = v; req_a1 = a; req_b1 = b; req_op1 = op; req_shamt1 = sh; req_tag1 = tag;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single port-1 op on an otherwise quiet arbiter, compared with a literal result.
    task automatic directed_op1(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [4:0] sh,
                                input logic [3:0] tag, input logic [31:0] exp_data);
        logic seen;
        apply_stimulus(1, 1'b1, a, b, op, sh, tag);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check_output({name, "_alu_op"}, 64'(alu_op), 64'(op));
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid[1];
        end
        check_output({name, "_seen"}, 64'(seen), 64'd1);
        check_output({name, "_data_tag"}, 64'({rsp_tag1, rsp_data1}), 64'({tag, exp_data}));
        @(posedge clk); #1;
    endtask

    // Stimulus side: every accepted request queues its spec-derived result.
    always @(negedge clk) begin
        if (reset) begin
            if (req_valid[0] && req_ready[0])
                exp_q0.push_back({req_tag0, alu_model(req_a0, req_b0, req_op0, req_shamt0)});
            if (req_valid[1] && req_ready[1])
                exp_q1.push_back({req_tag1, alu_model(req_a1, req_b1, req_op1, req_shamt1)});
        end
    end

    always @(negedge reset) begin
        exp_q0.delete();
        exp_q1.delete();
    end

    // Monitor side: each consumed response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                check_output("rsp0_expected", 64'(exp_q0.size() != 0), 64'd1);
                if (exp_q0.size() != 0)
                    check_output("rsp0_data_tag", 64'({rsp_tag0, rsp_data0}), 64'(exp_q0.pop_front()));
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                check_output("rsp1_expected", 64'(exp_q1.size() != 0), 64'd1);
                if (exp_q1.size() != 0)
                    check_output("rsp1_data_tag", 64'({rsp_tag1, rsp_data1}), 64'(exp_q1.pop_front()));
            end
            check_output("grant_legal",
                         64'(((req_ready & ~req_valid) != 2'b00) || (req_ready == 2'b11)), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        apply_stimulus(0, 1'b0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1'b0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #7;
        check_output("reset_req_ready", 64'(req_ready), 64'd0);
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_rsp_data", {rsp_data0, rsp_data1}, 64'd0);
        check_output("reset_alu", 64'({alu_a, alu_op, alu_shamt, rsp_tag0, rsp_tag1}), 64'd0);
        check_output("reset_alu_b", 64'(alu_b), 64'd0);
        #14 reset = 1'b1;

        // Single ADD on port 0: accepted at once, response two edges later.
        @(posedge clk); #1;
        apply_stimulus(0, 1'b1, 32'd5, 32'd7, OP_ADD, 5'd0, 4'd3);
        @(negedge clk);
        check_output("first_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("first_alu_op", 64'(alu_op), 64'(OP_ADD));
        check_output("first_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        check_output("first_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_output("first_rsp_valid", 64'(rsp_valid), 64'd1);
        check_output("first_rsp", 64'({rsp_tag0, rsp_data0}), 64'({4'd3, 32'd12}));
        @(posedge clk); #1;

        directed_op1("sll31", 32'd0, 32'd1, OP_SLL, 5'd31, 4'd1, 32'h8000_0000);
        directed_op1("lui", 32'd0, 32'h1234, OP_LUI, 5'd0, 4'd2, 32'h1234_0000);
        directed_op1("sub", 32'd10, 32'd3, OP_SUB, 5'd0, 4'd4, 32'd7);
        directed_op1("signcom", 32'hFFFF_FFFF, 32'd1, OP_SIGNCOM, 5'd0, 4'd5, 32'd1);
        directed_op1("op9", 32'd77, 32'd88, 4'd9, 5'd3, 4'd6, 32'd0);
        idle(3);

        // Contention: both ports asking every cycle, grants must alternate from port 0.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 1'b1, 32'(i), 32'd100, OP_ADD, 5'd0, 4'(i));
            if ((i / 2) % 2 == 0) apply_stimulus(1, 1'b1, 32'd10, 32'd3, OP_SUB, 5'd0, 4'(i));
            else apply_stimulus(1, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_SIGNCOM, 5'd0, 4'(i));
            @(negedge clk);
            check_output("contend_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
        end
        idle(4);

        // Backpressure on port 0: slot and issue register fill, then drain without a gap.
        rsp_ready = 2'b10;
        apply_stimulus(0, 1'b1, 32'd1, 32'd1, OP_ADD, 5'd0, 4'd1);
        @(negedge clk);
        check_output("bp_accept1", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        apply_stimulus(0, 1'b1, 32'd2, 32'd2, OP_ADD, 5'd0, 4'd2);
        @(negedge clk);
        check_output("bp_accept2", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        apply_stimulus(0, 1'b1, 32'd3, 32'd3, OP_ADD, 5'd0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("bp_stall", 64'(req_ready[0]), 64'd0);
            check_output("bp_hold", 64'({rsp_valid[0], rsp_data0}), 64'({1'b1, 32'd2}));
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check_output("bp_resume", 64'({req_ready[0], rsp_data0}), 64'({1'b1, 32'd2}));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("bp_nobubble2", 64'({rsp_valid[0], rsp_data0}), 64'({1'b1, 32'd4}));
        @(posedge clk); #1;
        @(negedge clk);
        check_output("bp_nobubble3", 64'({rsp_valid[0], rsp_data0}), 64'({1'b1, 32'd6}));
        @(posedge clk); #1;
        idle(4);

        // Fixed-priority instance: port 0 wins every cycle, port 1 gets in only when 0 drops.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1'b1, 32'(i), 32'd1, OP_OR, 5'd0, 4'(i));
            apply_stimulus(1, 1'b1, 32'd9, 32'(i), OP_ADD, 5'd0, 4'(i));
            @(negedge clk);
            check_output("fixed_grant0", 64'(f_req_ready), 64'd1);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("fixed_grant1", 64'(f_req_ready), 64'd2);
        @(posedge clk); #1;
        idle(4);

        // Random traffic including unused opcodes and random response backpressure.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(0, 1'($urandom), $urandom, $urandom, 4'($urandom_range(0, 15)),
                           5'($urandom), 4'($urandom));
            apply_stimulus(1, 1'($urandom), $urandom, $urandom, 4'($urandom_range(0, 15)),
                           5'($urandom), 4'($urandom));
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        idle(10);
        check_output("drain_q0", 64'(exp_q0.size()), 64'd0);
        check_output("drain_q1", 64'(exp_q1.size()), 64'd0);

        // Reset between the issue edge and the result edge drops the op entirely.
        apply_stimulus(0, 1'b1, 32'd40, 32'd2, OP_ADD, 5'd0, 4'd9);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2 reset = 1'b0;
        #1;
        check_output("midreset_alu", 64'({alu_a, alu_op, alu_shamt}), 64'd0);
        check_output("midreset_rsp", 64'({rsp_valid, req_ready, rsp_data0}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("post_reset_quiet", 64'(rsp_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
